// File: rtl/audio_mixer_dac_if.sv
// Control, sample and status signals of the audio mixer/DAC, grouped for the
// system side (master) and the mixer (slave).
interface audio_mixer_dac_if #(
    parameter int WIDTH    = 14,
    parameter int CHANNELS = 3,
    parameter int VOL_BITS = 4
);
    logic                         ce_sample;
    logic [CHANNELS*WIDTH-1:0]    ch_in;
    logic [CHANNELS*VOL_BITS-1:0] ch_vol;
    logic                         tape_in;
    logic                         tape_out;
    logic [1:0]                   mode;
    logic                         clip_clr;
    logic [WIDTH-1:0]             pcm_o;
    logic                         dac_o;
    logic                         busy;
    logic                         clip;

    modport master (
        output ce_sample, ch_in, ch_vol, tape_in, tape_out, mode, clip_clr,
        input  pcm_o, dac_o, busy, clip
    );

    modport slave (
        input  ce_sample, ch_in, ch_vol, tape_in, tape_out, mode, clip_clr,
        output pcm_o, dac_o, busy, clip
    );
endinterface

// File: rtl/audio_mixer_dac.sv
// Multi-channel PCM mixer with per-channel volume, tape routing, saturation and
// a first-order delta-sigma bitstream output.
module audio_mixer_dac #(
    parameter int WIDTH    = 14,
    parameter int CHANNELS = 3,
    parameter int VOL_BITS = 4
) (
    input  logic                clk_sys,
    input  logic                res_n,
    audio_mixer_dac_if.slave    bus
);
    localparam int ACC_W = WIDTH + VOL_BITS + $clog2(CHANNELS + 2);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PRD_W = WIDTH + VOL_BITS;
    localparam logic [ACC_W-1:0] FULL_SCALE = {{(ACC_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [ACC_W-1:0] TAPE_MON   = ACC_W'(2**(WIDTH-2));

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [ACC_W-1:0]             acc_q, acc_d;
    logic [1:0]                   mode_q, mode_d;
    logic [CHANNELS*WIDTH-1:0]    ch_q, ch_d;
    logic [CHANNELS*VOL_BITS-1:0] vol_q, vol_d;
    logic                         tin_q, tin_d;
    logic                         tout_q, tout_d;
    logic [WIDTH-1:0]             pcm_q, pcm_d;
    logic                         busy_q, busy_d;
    logic                         clip_q, clip_d;
    logic [WIDTH-1:0]             ds_q, ds_d;
    logic                         dac_q, dac_d;

    logic [WIDTH-1:0]    cur_ch;
    logic [VOL_BITS-1:0] cur_vol;
    logic [PRD_W-1:0]    prod;
    logic [ACC_W-1:0]    raw;
    logic [WIDTH:0]      ds_sum;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mode_d  = mode_q;
        ch_d    = ch_q;
        vol_d   = vol_q;
        tin_d   = tin_q;
        tout_d  = tout_q;
        pcm_d   = pcm_q;
        busy_d  = busy_q;
        clip_d  = bus.clip_clr ? 1'b0 : clip_q;

        cur_ch  = ch_q[idx_q*WIDTH +: WIDTH];
        cur_vol = vol_q[idx_q*VOL_BITS +: VOL_BITS];
        prod    = PRD_W'(cur_ch) * PRD_W'(cur_vol);

        unique case (mode_q)
            2'b00:   raw = acc_q;
            2'b01:   raw = tout_q ? FULL_SCALE : '0;
            2'b10:   raw = acc_q + (tin_q ? TAPE_MON : '0);
            default: raw = '0;
        endcase

        unique case (state_q)
            IDLE: begin
                if (bus.ce_sample) begin
                    mode_d  = bus.mode;
                    ch_d    = bus.ch_in;
                    vol_d   = bus.ch_vol;
                    tin_d   = bus.tape_in;
                    tout_d  = bus.tape_out;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                // Each term is truncated on its own before summing.
                acc_d = acc_q + ACC_W'(prod[PRD_W-1:VOL_BITS]);
                if (idx_q == IDX_W'(CHANNELS - 1)) begin
                    idx_d   = '0;
                    state_d = SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SAT: begin
                if (|raw[ACC_W-1:WIDTH]) begin
                    pcm_d  = '1;
                    clip_d = 1'b1;
                end else begin
                    pcm_d = raw[WIDTH-1:0];
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // {dac_q, ds_q} is the WIDTH+1 bit modulator register; its carry is the output bit.
        ds_sum = {1'b0, ds_q} + {1'b0, pcm_q};
        ds_d   = ds_sum[WIDTH-1:0];
        dac_d  = ds_sum[WIDTH];
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mode_q  <= '0;
            ch_q    <= '0;
            vol_q   <= '0;
            tin_q   <= 1'b0;
            tout_q  <= 1'b0;
            pcm_q   <= '0;
            busy_q  <= 1'b0;
            clip_q  <= 1'b0;
            ds_q    <= '0;
            dac_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            vol_q   <= vol_d;
            tin_q   <= tin_d;
            tout_q  <= tout_d;
            pcm_q   <= pcm_d;
            busy_q  <= busy_d;
            clip_q  <= clip_d;
            ds_q    <= ds_d;
            dac_q   <= dac_d;
        end
    end

    assign bus.pcm_o = pcm_q;
    assign bus.dac_o = dac_q;
    assign bus.busy  = busy_q;
    assign bus.clip  = clip_q;
endmodule
